// File: rtl/student_fir_mac_if.sv
// Sample/coefficient/result bundle between a serial FIR MAC core and its driver.
interface student_fir_mac_if #(
  parameter int unsigned DATA_SIZE         = 16,
  parameter int unsigned COEFF_SIZE        = 16,
  parameter int unsigned NUM_TAPS          = 8,
  parameter int unsigned DATA_SIZE_FIR_OUT = 32
) ();
  logic                           valid_strobe_in;
  logic [DATA_SIZE-1:0]           sample_in;
  logic                           coeff_we;
  logic [$clog2(NUM_TAPS)-1:0]    coeff_addr;
  logic [COEFF_SIZE-1:0]          coeff_wdata;
  logic                           busy;
  logic [DATA_SIZE_FIR_OUT-2:0]   fir_out;
  logic                           valid_strobe_out;
  logic                           sat_flag;
  logic                           sample_dropped;

  modport master (
    output valid_strobe_in, sample_in, coeff_we, coeff_addr, coeff_wdata,
    input  busy, fir_out, valid_strobe_out, sat_flag, sample_dropped
  );

  modport slave (
    input  valid_strobe_in, sample_in, coeff_we, coeff_addr, coeff_wdata,
    output busy, fir_out, valid_strobe_out, sat_flag, sample_dropped
  );
endinterface

// File: rtl/student_fir_mac.sv
// Serial multiply-accumulate FIR core: one tap per cycle, saturated result
// presented with a one-cycle valid strobe.
module student_fir_mac #(
  parameter int unsigned DATA_SIZE         = 16,
  parameter int unsigned COEFF_SIZE        = 16,
  parameter int unsigned NUM_TAPS          = 8,
  parameter int unsigned DATA_SIZE_FIR_OUT = 32
) (
  input logic              clk,
  input logic              rst_ni,
  student_fir_mac_if.slave bus
);
  localparam int unsigned AW    = $clog2(NUM_TAPS);
  localparam int unsigned PW    = DATA_SIZE + COEFF_SIZE;
  localparam int unsigned ACC_W = PW + AW;
  localparam int unsigned W     = DATA_SIZE_FIR_OUT - 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;
  state_e state_q, state_d;

  logic signed [DATA_SIZE-1:0]  x_q [NUM_TAPS];
  logic signed [COEFF_SIZE-1:0] c_q [NUM_TAPS];
  logic signed [ACC_W-1:0]      acc_q;
  logic [AW-1:0]                k_q;
  logic signed [PW-1:0]         prod;
  logic [W-1:0]                 fir_q;
  logic                         sat_q, vout_q, drop_q;
  logic                         last_tap, coeff_ok;
  logic                         busy, start, mac_en, done, coeff_wr;

  assign last_tap = (k_q == AW'(NUM_TAPS - 1));
  assign prod     = PW'(x_q[k_q]) * PW'(c_q[k_q]);

  // With a power-of-two tap count every address is a valid tap index.
  if (2**AW == NUM_TAPS) begin : g_addr_full
    assign coeff_ok = 1'b1;
  end else begin : g_addr_part
    assign coeff_ok = (32'(bus.coeff_addr) < NUM_TAPS);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.valid_strobe_in) state_d = MAC;
      MAC:     if (last_tap)            state_d = DONE;
      DONE:                             state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    start    = (state_q == IDLE) && bus.valid_strobe_in;
    mac_en   = (state_q == MAC);
    done     = (state_q == DONE);
    coeff_wr = (state_q == IDLE) && bus.coeff_we && coeff_ok;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      acc_q  <= '0;
      k_q    <= '0;
      fir_q  <= '0;
      sat_q  <= 1'b0;
      vout_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      // Coefficient write lands before the MAC phase reads it, so a same-cycle
      // strobe already sees the new value.
      if (coeff_wr) c_q[bus.coeff_addr] <= bus.coeff_wdata;
      if (start) begin
        x_q[0] <= bus.sample_in;
        for (int unsigned i = 1; i < NUM_TAPS; i++) x_q[i] <= x_q[i-1];
        acc_q <= '0;
        k_q   <= '0;
      end
      if (mac_en) begin
        acc_q <= acc_q + ACC_W'(prod);
        k_q   <= k_q + AW'(1);
      end
      vout_q <= done;
      if (done) begin
        if (acc_q > ACC_MAX) begin
          fir_q <= {1'b0, {(W-1){1'b1}}};
          sat_q <= 1'b1;
        end else if (acc_q < ACC_MIN) begin
          fir_q <= {1'b1, {(W-1){1'b0}}};
          sat_q <= 1'b1;
        end else begin
          fir_q <= acc_q[W-1:0];
          sat_q <= 1'b0;
        end
      end
      if (bus.valid_strobe_in && busy) drop_q <= 1'b1;
    end
  end

  assign bus.busy             = busy;
  assign bus.fir_out          = fir_q;
  assign bus.valid_strobe_out = vout_q;
  assign bus.sat_flag         = sat_q;
  assign bus.sample_dropped   = drop_q;
endmodule

// File: tb/tb_student_fir_mac.sv
// Scoreboard bench for student_fir_mac: a reference model queues expected
// results at each accepted strobe; the monitor pops them on valid_strobe_out.
module tb_student_fir_mac;
  localparam int unsigned DATA_SIZE         = 16;
  localparam int unsigned COEFF_SIZE        = 16;
  localparam int unsigned NUM_TAPS          = 8;
  localparam int unsigned DATA_SIZE_FIR_OUT = 32;
  localparam int unsigned AW                = $clog2(NUM_TAPS);
  localparam int unsigned W                 = DATA_SIZE_FIR_OUT - 1;
  localparam int          SPACING           = NUM_TAPS + 2;
  localparam longint      SAT_MAX           = (longint'(1) <<< (W-1)) - 1;
  localparam longint      SAT_MIN           = -(longint'(1) <<< (W-1));

  logic clk = 1'b0;
  logic rst_ni;

  student_fir_mac_if #(
    .DATA_SIZE(DATA_SIZE), .COEFF_SIZE(COEFF_SIZE),
    .NUM_TAPS(NUM_TAPS), .DATA_SIZE_FIR_OUT(DATA_SIZE_FIR_OUT)
  ) bus ();

  student_fir_mac #(
    .DATA_SIZE(DATA_SIZE), .COEFF_SIZE(COEFF_SIZE),
    .NUM_TAPS(NUM_TAPS), .DATA_SIZE_FIR_OUT(DATA_SIZE_FIR_OUT)
  ) dut (
    .clk(clk),
    .rst_ni(rst_ni),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint fir;
    bit     sat;
    int     due;
  } exp_t;

  exp_t   sb[$];
  int     cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  longint mx[NUM_TAPS];
  longint mc[NUM_TAPS];
  int     t_last;
  bit     have_t;
  bit     drop_exp;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    have_t   = 1'b0;
    drop_exp = 1'b0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      mx[i] = 0;
      mc[i] = 0;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One input cycle; called at a negedge, returns at the next negedge.
  task automatic step(input bit stb, input logic signed [63:0] smp,
                      input bit we, input int addr, input logic signed [63:0] wd);
    bit     is_idle;
    longint acc;
    exp_t   e;
    logic [DATA_SIZE-1:0]  s16;
    logic [COEFF_SIZE-1:0] c16;
    s16 = smp[DATA_SIZE-1:0];
    c16 = wd[COEFF_SIZE-1:0];
    bus.valid_strobe_in = stb;
    bus.sample_in       = s16;
    bus.coeff_we        = we;
    bus.coeff_addr      = addr[AW-1:0];
    bus.coeff_wdata     = c16;
    is_idle = !have_t || (cyc >= t_last + SPACING);
    if (we && is_idle && addr < int'(NUM_TAPS)) mc[addr] = $signed(c16);
    if (stb) begin
      if (is_idle) begin
        for (int i = NUM_TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0]  = $signed(s16);
        t_last = cyc;
        have_t = 1'b1;
        acc    = 0;
        for (int k = 0; k < NUM_TAPS; k++) acc += mx[k] * mc[k];
        e.sat = (acc > SAT_MAX) || (acc < SAT_MIN);
        e.fir = (acc > SAT_MAX) ? SAT_MAX : ((acc < SAT_MIN) ? SAT_MIN : acc);
        e.due = cyc + SPACING;
        sb.push_back(e);
      end else begin
        drop_exp = 1'b1;
      end
    end
    @(negedge clk);
    bus.valid_strobe_in = 1'b0;
    bus.coeff_we        = 1'b0;
  endtask

  task automatic wr(input int addr, input logic signed [63:0] wd);
    step(1'b0, 0, 1'b1, addr, wd);
  endtask

  task automatic strobe(input logic signed [63:0] smp);
    step(1'b1, smp, 1'b0, 0, 0);
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},    bus.busy, 0);
    check({tag, "_fir_out"}, bus.fir_out, 0);
    check({tag, "_valid"},   bus.valid_strobe_out, 0);
    check({tag, "_sat"},     bus.sat_flag, 0);
    check({tag, "_dropped"}, bus.sample_dropped, 0);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    cyc++;
    #1;
    if (bus.valid_strobe_out === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("fir_out",  $signed(bus.fir_out), e.fir);
        check("sat_flag", bus.sat_flag, e.sat);
        check("latency",  cyc, e.due);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_strobe_in = 1'b0;
    bus.sample_in       = '0;
    bus.coeff_we        = 1'b0;
    bus.coeff_addr      = '0;
    bus.coeff_wdata     = '0;
    rst_ni              = 1'b0;
    model_clear();
    wait_cycles(3);
    check_reset_state("reset");
    rst_ni = 1'b1;
    wait_cycles(2);

    // Impulse response
    for (int k = 0; k < NUM_TAPS; k++) wr(k, k + 1);
    strobe(1);
    check("busy_in_mac", bus.busy, 1);
    wait_cycles(SPACING - 1);
    for (int i = 0; i < NUM_TAPS; i++) begin
      strobe(0);
      wait_cycles(SPACING - 1);
    end
    drain();
    check("dropped_clear", bus.sample_dropped, 0);

    // Positive saturation
    for (int k = 0; k < NUM_TAPS; k++) wr(k, 16'sh7FFF);
    for (int i = 0; i < NUM_TAPS; i++) begin
      strobe(16'sh7FFF);
      wait_cycles(SPACING - 1);
    end
    drain();

    // Negative saturation, then an in-range result clears sat_flag
    for (int i = 0; i < NUM_TAPS; i++) begin
      strobe(-32768);
      wait_cycles(SPACING - 1);
    end
    wr(0, 1);
    for (int k = 1; k < NUM_TAPS; k++) wr(k, 0);
    strobe(3);
    wait_cycles(SPACING - 1);
    drain();

    // Strobe while busy is dropped and does not shift the delay line
    strobe(5);
    wait_cycles(2);
    strobe(7);
    wait_cycles(SPACING);
    drain();
    check("dropped_sticky", bus.sample_dropped, drop_exp);
    wr(0, 0);
    wr(1, 1);
    strobe(0);
    wait_cycles(SPACING - 1);
    drain();

    // Coefficient write during MAC ignored; in IDLE it joins a same-cycle strobe
    wr(0, 1);
    wr(1, 0);
    strobe(4);
    wait_cycles(2);
    wr(0, 9);
    wait_cycles(SPACING);
    drain();
    step(1'b1, 2, 1'b1, 0, 9);
    wait_cycles(SPACING - 1);
    drain();
    check("fir_out_hold", $signed(bus.fir_out), 18);

    // Reset in the third MAC cycle aborts the computation
    strobe(100);
    wait_cycles(2);
    rst_ni = 1'b0;
    model_clear();
    wait_cycles(2);
    check_reset_state("abort");
    rst_ni = 1'b1;
    wait_cycles(1);
    strobe(100);
    wait_cycles(SPACING - 1);
    drain();
    wait_cycles(SPACING);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/student_fir_mac.md
Name: student_fir_mac

Overview:
Serial multiply-accumulate FIR filter core, one per channel. It is the stage directly upstream of the pairwise summing adders in the parallel FIR array. On each input sample strobe it computes one filter output over NUM_TAPS taps, one tap per cycle. It then presents a saturated result with a one-cycle valid strobe, at the width the adder stage consumes on fir_out_a / fir_out_b.

Parameters:
DATA_SIZE, 16, signed input sample width
COEFF_SIZE, 16, signed coefficient width
NUM_TAPS, 8, number of taps; must be >= 2
DATA_SIZE_FIR_OUT, 32, system FIR output size; the block outputs DATA_SIZE_FIR_OUT-1 bits

Ports:
clk  input  1  clock, rising edge
rst_ni  input  1  reset, asynchronous, active-low
valid_strobe_in  input  1  one-cycle strobe; sample_in is valid
sample_in  input  DATA_SIZE  signed input sample
coeff_we  input  1  coefficient write enable
coeff_addr  input  $clog2(NUM_TAPS)  coefficient index (tap k)
coeff_wdata  input  COEFF_SIZE  signed coefficient value
busy  output  1  high while a computation is in progress (state != IDLE)
fir_out  output  DATA_SIZE_FIR_OUT-1  signed saturated filter result
valid_strobe_out  output  1  one-cycle pulse; fir_out updated
sat_flag  output  1  high with the current fir_out if that result was saturated
sample_dropped  output  1  sticky; set when a strobe arrives while busy

Behaviour:
- Reset (async, rst_ni low):
  - state = IDLE.
  - Delay line x[0..NUM_TAPS-1], coefficients c[0..NUM_TAPS-1], accumulator, tap counter, fir_out and sat_flag all go to 0.
  - valid_strobe_out = 0, busy = 0, sample_dropped = 0.
- Reset mid-operation aborts the computation. No valid_strobe_out is issued for it.
- FSM states:
  - IDLE: valid_strobe_in=1 -> shift delay line (x[k] <= x[k-1], x[0] <= sample_in), acc <= 0, k <= 0, go to MAC.
  - MAC: acc <= acc + x[k]*c[k] (signed), k <= k+1. After the k=NUM_TAPS-1 accumulate, go to DONE. Duration is exactly NUM_TAPS cycles.
  - DONE: saturate acc into fir_out, set sat_flag, pulse valid_strobe_out for one cycle, go to IDLE.
- Latency: valid_strobe_out is high in cycle T+NUM_TAPS+2, where T is the cycle valid_strobe_in was sampled high. Minimum strobe spacing for lossless operation is NUM_TAPS+2 cycles.
- Arithmetic:
  - Product width is DATA_SIZE+COEFF_SIZE.
  - Accumulator width is DATA_SIZE+COEFF_SIZE+$clog2(NUM_TAPS) and never overflows internally.
  - Output limits for W = DATA_SIZE_FIR_OUT-1: acc > 2^(W-1)-1 -> fir_out = 2^(W-1)-1; acc < -2^(W-1) -> fir_out = -2^(W-1). In both cases sat_flag=1, otherwise sat_flag=0.
- fir_out and sat_flag hold their values between results.
- A strobe while busy (MAC or DONE) is ignored: the delay line is unchanged and sample_dropped is set. sample_dropped clears only on reset.
- Coefficient writes:
  - Accepted only in IDLE: c[coeff_addr] <= coeff_wdata. Writes in MAC/DONE are ignored, so coefficients are constant during a computation.
  - A write and a strobe in the same IDLE cycle are both applied. The started computation uses the new coefficient.
  - coeff_addr >= NUM_TAPS: the write is ignored.

Test Plan:
- Impulse: c = 1,2,...,8; send sample 1, then 8 samples of 0, spaced 10 cycles -> fir_out = 1,2,...,8, then 0. Each valid pulse comes exactly 10 cycles after its strobe; sat_flag=0.
- Positive saturation: all c = 0x7FFF; 8 samples of 0x7FFF -> 8th result acc = 0x1_FFF8_0008, fir_out = 0x3FFF_FFFF, sat_flag=1.
- Negative saturation: all c = 0x7FFF; 8 samples of 0x8000 -> 8th result fir_out = 0x4000_0000 (-2^30), sat_flag=1. The next computation with acc in range -> sat_flag=0.
- Dropped strobe: strobe sample 5 with c[0]=1 and the other taps 0; strobe again 3 cycles later -> exactly one valid pulse with fir_out=5, sample_dropped=1, delay line x[1]=0 (not the second sample).
- Coefficient write while busy: write c[0]=9 during MAC -> ignored. The next result uses the old c[0]. The same write in IDLE takes effect for a strobe in the same cycle.
- Reset mid-MAC: assert rst_ni=0 at MAC cycle 3 -> no valid pulse; fir_out=0, busy=0, coefficients=0. After release, the first computation returns 0.
